m_nspi_frame: RTL

- Parametrised multi-word SPI frame sequencer; successor to the fixed 64-bit, two-word transfer block.
- Splits a FRAME_W = WORD_W*N_WORDS transmit frame into words and hands each word to the word-level SPI controller (m_spi_control) through a start/busy handshake.
- Reassembles received words into a frame; adds word-order mode, a programmable inter-word gap, per-word timeout and abort.
- Sits between user logic and m_spi_control / SPI_MASTER_Top.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/m_nspi_wdog.sv | 40 ++++
 rtl/m_nspi_frame.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the multi-word SPI frame sequencer: FSM encoding,
// default word width and the word-slice offset helper.
package spi_pkg;

  localparam int unsigned WORD_W_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_REQ  = 3'd2,
    S_XFER = 3'd3,
    S_NEXT = 3'd4,
    S_GAP  = 3'd5
  } nspi_state_e;

  // Bit offset of word idx inside the frame; MSW-first walks from the top slice down.
  function automatic int unsigned f_word_off(
    input int unsigned idx,
    input int unsigned n_words,
    input bit          msw_first,
    input int unsigned word_w
  );
    int unsigned pos;
    if (msw_first) begin
      pos = n_words - 32'd1 - idx;
    end else begin
      pos = idx;
    end
    return pos * word_w;
  endfunction

endpackage

// File: rtl/m_nspi_wdog.sv
// Loadable down-counter shared by the inter-word gap and the handshake timeout.
// expired_o flags the last counted cycle of a nonzero load.
module m_nspi_wdog #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             enable_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // load wins over counting; the count parks at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (enable_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/m_nspi_frame.sv
// Multi-word SPI frame sequencer: splits a frame into words for m_spi_control
// through a start/busy handshake and reassembles the returned words.
module m_nspi_frame
  import spi_pkg::*;
#(
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter int unsigned N_WORDS   = 2,
  parameter bit          MSW_FIRST = 1'b0,
  parameter int unsigned GAP_W     = 8,
  parameter int unsigned TMO_W     = 16
) (
  input  logic                      I_CLK,
  input  logic                      I_RESETN,
  input  logic                      start,
  input  logic                      abort,
  input  logic [GAP_W-1:0]          gap_cfg,
  input  logic [TMO_W-1:0]          tmo_cfg,
  input  logic [WORD_W*N_WORDS-1:0] tx_frame,
  output logic [WORD_W*N_WORDS-1:0] rx_frame,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      word_send,
  output logic [WORD_W-1:0]         word_tx,
  input  logic [WORD_W-1:0]         word_rx,
  input  logic                      word_busy
);

  localparam int unsigned FRAME_W = WORD_W * N_WORDS;
  localparam int unsigned IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned OFF_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned CNT_W   = (GAP_W > TMO_W) ? GAP_W : TMO_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  nspi_state_e        state_q, state_d, nxt_s;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
  logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [FRAME_W-1:0] rx_frame_q, rx_frame_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               send_q, send_d;
  logic [WORD_W-1:0]  word_tx_q, word_tx_d;

  logic               is_last_s, accept_s, tmo_hit_s, fail_s;
  logic               wd_load_s, wd_en_s, wd_exp_s;
  logic [CNT_W-1:0]   wd_val_s;
  logic [OFF_W-1:0]   off_s;

  // The done cycle is treated as part of the frame, so a start there is refused.
  assign accept_s  = (state_q == S_IDLE) && start && !done_q;
  assign is_last_s = (idx_q == LAST_IDX);
  assign off_s     = OFF_W'(f_word_off(32'(idx_q), N_WORDS, MSW_FIRST, WORD_W));
  assign tmo_hit_s = ((state_q == S_REQ) || (state_q == S_XFER)) &&
                     (tmo_q != {TMO_W{1'b0}}) && wd_exp_s;
  assign fail_s    = (state_q != S_IDLE) && (abort || tmo_hit_s);

  assign wd_load_s = (state_q == S_LOAD) ||
                     ((state_q == S_REQ) && word_busy) ||
                     ((state_q == S_NEXT) && !is_last_s && (gap_q != {GAP_W{1'b0}}));
  assign wd_val_s  = (state_q == S_NEXT) ? CNT_W'(gap_q) : CNT_W'(tmo_q);
  assign wd_en_s   = (state_q == S_REQ) || (state_q == S_XFER) || (state_q == S_GAP);

  m_nspi_wdog #(
    .CNT_W (CNT_W)
  ) u_wdog (
    .clk_i     (I_CLK),
    .rst_ni    (I_RESETN),
    .load_i    (wd_load_s),
    .value_i   (wd_val_s),
    .enable_i  (wd_en_s),
    .expired_o (wd_exp_s)
  );

  // next-state logic; abort/timeout override every other transition
  always_comb begin
    nxt_s = state_q;
    case (state_q)
      S_IDLE: if (accept_s) nxt_s = S_LOAD; else nxt_s = S_IDLE;
      S_LOAD: nxt_s = S_REQ;
      S_REQ:  if (word_busy) nxt_s = S_XFER; else nxt_s = S_REQ;
      S_XFER: if (!word_busy) nxt_s = S_NEXT; else nxt_s = S_XFER;
      S_NEXT: begin
        if (is_last_s) begin
          nxt_s = S_IDLE;
        end else if (gap_q != {GAP_W{1'b0}}) begin
          nxt_s = S_GAP;
        end else begin
          nxt_s = S_LOAD;
        end
      end
      S_GAP:  if (wd_exp_s) nxt_s = S_LOAD; else nxt_s = S_GAP;
      default: nxt_s = S_IDLE;
    endcase
    if (fail_s) begin
      state_d = S_IDLE;
    end else begin
      state_d = nxt_s;
    end
  end

  // outputs and datapath next values
  always_comb begin
    idx_d      = idx_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    rx_frame_d = rx_frame_q;
    err_d      = err_q;
    word_tx_d  = word_tx_q;
    done_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);
    send_d     = (state_d == S_REQ);
    if (accept_s) begin
      tx_sh_d = tx_frame;
      gap_d   = gap_cfg;
      tmo_d   = tmo_cfg;
      rx_sh_d = {FRAME_W{1'b0}};
      err_d   = 1'b0;
      idx_d   = {IDX_W{1'b0}};
    end else if (fail_s) begin
      err_d = 1'b1;
    end else begin
      case (state_q)
        S_LOAD: word_tx_d = tx_sh_q[off_s +: WORD_W];
        S_XFER: begin
          if (!word_busy) begin
            rx_sh_d[off_s +: WORD_W] = word_rx;
          end else begin
            rx_sh_d = rx_sh_q;
          end
        end
        S_NEXT: begin
          if (is_last_s) begin
            rx_frame_d = rx_sh_q;
            done_d     = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: idx_d = idx_q;
      endcase
    end
  end

  // state and register bank
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      state_q    <= S_IDLE;
      idx_q      <= {IDX_W{1'b0}};
      tx_sh_q    <= {FRAME_W{1'b0}};
      rx_sh_q    <= {FRAME_W{1'b0}};
      gap_q      <= {GAP_W{1'b0}};
      tmo_q      <= {TMO_W{1'b0}};
      rx_frame_q <= {FRAME_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      send_q     <= 1'b0;
      word_tx_q  <= {WORD_W{1'b0}};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      rx_frame_q <= rx_frame_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      send_q     <= send_d;
      word_tx_q  <= word_tx_d;
    end
  end

  assign rx_frame  = rx_frame_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign word_send = send_q;
  assign word_tx   = word_tx_q;

endmodule
